// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch front end: PC width, reset/exception
// vectors and the {pc, inst} entry carried through the fetch FIFOs.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT   = 32'hBFC0_0000;
    localparam logic [XLEN-1:0] EXC_VECTOR_DEFAULT = 32'h8000_0080;
    localparam logic [XLEN-1:0] INST_BYTES         = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Sequential PC; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t with push/pop/flush and an occupancy count.
// Push while full is accepted only together with a pop. Flush wins over push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // Storage write; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy update.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: PC generation, pipelined imem requests and a
// DEPTH-entry instruction queue feeding decode over valid/ready.
// Redirects (branch or exception) flush the queue and mark every outstanding
// imem response as stale so it is dropped on return.
// Optional build macro FETCH_STATS_EN adds stat_fetched / stat_flushed counters.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] EXC_VECTOR      = EXC_VECTOR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br,
    input  logic [XLEN-1:0] br_target,
    input  logic            except,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] inst_out,
    input  logic            out_ready
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]     stat_fetched,
    output logic [31:0]     stat_flushed
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic [OUT_W-1:0] discard_q;
    logic [OUT_W-1:0] discard_d;

    // The request-PC FIFO holds exactly the granted-but-unreturned requests,
    // so its occupancy is the in-flight count.
    logic [OUT_W-1:0] inflight;
    logic [CNT_W-1:0] count;

    logic redirect;
    logic grant;
    logic rsp;
    logic rsp_keep;
    logic handoff;

    fetch_entry_t q_head;
    fetch_entry_t q_push_data;
    fetch_entry_t rpc_head;
    fetch_entry_t rpc_push_data;

    assign redirect = br | except;
    assign grant    = imem_req & imem_gnt;
    // Ignore a response with nothing outstanding so counters cannot underflow.
    assign rsp      = imem_rvalid & (inflight != '0);
    // Responses returning in a redirect cycle or while stale ones drain are dropped.
    assign rsp_keep = rsp & ~redirect & (discard_q == '0);
    assign handoff  = out_valid & out_ready;

    assign imem_addr = pc_q;

    // Issue when not redirecting and both the in-flight limit and queue credits allow.
    always_comb begin
        imem_req = 1'b0;
        if (!rst && !redirect && (32'(inflight) < MAX_OUTSTANDING) &&
            ((32'(count) + 32'(inflight)) < DEPTH)) begin
            imem_req = 1'b1;
        end
    end

    // Next PC: exception beats branch beats sequential advance on grant.
    always_comb begin
        pc_d = pc_q;
        if (except) begin
            pc_d = EXC_VECTOR;
        end else if (br) begin
            pc_d = br_target;
        end else if (grant) begin
            pc_d = next_pc(pc_q);
        end
    end

    // Stale-response count. On redirect, every outstanding request becomes stale:
    // the previously stale ones plus the live ones, i.e. all of inflight, minus
    // the one returning (and being dropped) in this very cycle.
    always_comb begin
        discard_d = discard_q;
        if (redirect) begin
            discard_d = rsp ? (inflight - OUT_W'(1)) : inflight;
        end else if (rsp && (discard_q != '0)) begin
            discard_d = discard_q - OUT_W'(1);
        end
    end

    // PC and discard state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            discard_q <= '0;
        end else begin
            pc_q      <= pc_d;
            discard_q <= discard_d;
        end
    end

    // Build FIFO entries: request PC on grant, {request PC, word} on response.
    always_comb begin
        rpc_push_data      = '0;
        rpc_push_data.pc   = pc_q;
        q_push_data        = rpc_head;
        q_push_data.inst   = imem_rdata;
    end

    fetch_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_req_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant),
        .push_data (rpc_push_data),
        .pop       (rsp),
        .flush     (1'b0),
        .head      (rpc_head),
        .count     (inflight)
    );

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_inst_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_keep),
        .push_data (q_push_data),
        .pop       (handoff),
        .flush     (redirect),
        .head      (q_head),
        .count     (count)
    );

    // Head is valid purely from registered occupancy; data forced to zero when empty.
    always_comb begin
        out_valid = (count != '0);
        pc_out    = out_valid ? q_head.pc   : '0;
        inst_out  = out_valid ? q_head.inst : '0;
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetched_q;
    logic [31:0] flushed_q;
    logic [31:0] lost_entries;
    logic        dropped;

    // Entries lost to a redirect exclude the one handed to decode that cycle.
    assign lost_entries = redirect ? (32'(count) - 32'(handoff)) : 32'd0;
    assign dropped      = rsp & ~rsp_keep;

    // Statistics counters; free-running, wrap at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            fetched_q <= fetched_q + 32'(rsp_keep);
            flushed_q <= flushed_q + lost_entries + 32'(dropped);
        end
    end

    assign stat_fetched = fetched_q;
    assign stat_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the stimulus loads the expected {pc, inst}
// stream into a queue, a monitor pops and compares on every handoff to decode.
// A behavioural imem with configurable latency and grant rate answers requests.
module tb_fetch_queue;

    localparam logic [31:0] KEY = 32'h5A5A_C3C3;

    logic        clk = 1'b0;
    logic        rst;
    logic        br;
    logic [31:0] br_target;
    logic        except;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        out_ready;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_flushed;
`endif

    fetch_queue #(
        .DEPTH           (4),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (32'hBFC0_0000),
        .EXC_VECTOR      (32'h8000_0080)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .br          (br),
        .br_target   (br_target),
        .except      (except),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .pc_out      (pc_out),
        .inst_out    (inst_out),
        .out_ready   (out_ready)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched (stat_fetched),
        .stat_flushed (stat_flushed)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    pend_t       pend[$];
    exp_t        exp_q[$];
    int          cyc     = 0;
    int          lat     = 1;
    int          gnt_pct = 100;
    int          grants  = 0;
    int          pops    = 0;
    int          n_cmp   = 0;
    int          n_bad   = 0;
    logic        g_seen  = 1'b0;
    logic [31:0] a_seen  = '0;

    // Request sampling away from the clock edge.
    always @(negedge clk) begin
        g_seen = imem_req & imem_gnt;
        a_seen = imem_addr;
    end

    // Instruction memory: word = addr ^ KEY, returned lat cycles after grant, in order.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                pend.delete();
                grants = 0;
            end else if (g_seen) begin
                pend.push_back('{a_seen, cyc + lat - 1});
                grants++;
            end
            #1;
            if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend[0].addr ^ KEY;
                void'(pend.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'hDEAD_BEEF;
            end
            imem_gnt = ($urandom_range(0, 99) < gnt_pct);
        end
    end

    // Monitor: every handoff must match the head of the expected stream.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                pops = 0;
            end else if (out_valid && out_ready) begin
                pops++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_output: got pc %h inst %h, expected none",
                             pc_out, inst_out);
                end else begin
                    e = exp_q.pop_front();
                    if (pc_out !== e.pc || inst_out !== e.inst) begin
                        n_bad++;
                        $display("FAIL stream_word: got pc %h inst %h, expected pc %h inst %h",
                                 pc_out, inst_out, e.pc, e.inst);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Contiguous stream from start; 32-bit addition wraps naturally.
    task automatic expect_stream(input logic [31:0] start);
        logic [31:0] p;
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            p = start + 32'(4 * i);
            exp_q.push_back('{p, p ^ KEY});
        end
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int start;
        int k;
        start = pops;
        k     = 0;
        while (pops < start + n && k < budget) begin
            step();
            k++;
        end
        n_cmp++;
        if (pops < start + n) begin
            n_bad++;
            $display("FAIL %s: timeout, got %0d outputs, expected %0d", name, pops - start, n);
        end
    endtask

    task automatic wait_inflight2(input string name);
        int k;
        k = 0;
        while ((pend.size() + int'(imem_rvalid)) < 2 && k < 30) begin
            step();
            k++;
        end
        n_cmp++;
        if ((pend.size() + int'(imem_rvalid)) < 2) begin
            n_bad++;
            $display("FAIL %s: timeout, got %0d in flight, expected 2", name,
                     pend.size() + int'(imem_rvalid));
        end
    endtask

    // Redirect in cycle N; returns at cycle N+2 after checking N and N+1.
    task automatic redirect(input logic b, input logic e, input logic [31:0] tgt,
                            input logic [31:0] new_start);
        br        = b;
        except    = e;
        br_target = tgt;
        @(negedge clk);
        check("req_low_on_redirect", 32'(imem_req), 32'd0);
        step();
        br     = 1'b0;
        except = 1'b0;
        expect_stream(new_start);
        @(negedge clk);
        check("addr_after_redirect", imem_addr, new_start);
        step();
    endtask

    logic [31:0] tgt_tab [8] = '{32'h0000_1000, 32'h0040_0100, 32'h0000_2000, 32'h7FFF_FFF0,
                                 32'h0010_0000, 32'h0000_3000, 32'hFFFF_FFF0, 32'h0020_0040};

    initial begin
        int p0;
        logic e;
        rst       = 1'b1;
        br        = 1'b0;
        except    = 1'b0;
        br_target = '0;
        out_ready = 1'b0;
        exp_q.delete();
        repeat (3) step();

        // Reset state.
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_imem_req", 32'(imem_req), 32'd0);
        check("reset_pc_out", pc_out, 32'd0);
        check("reset_inst_out", inst_out, 32'd0);
        check("reset_imem_addr", imem_addr, 32'hBFC0_0000);

        // 1: latency 1, always ready: one instruction per cycle from RESET_PC.
        step();
        lat       = 1;
        gnt_pct   = 100;
        out_ready = 1'b1;
        expect_stream(32'hBFC0_0000);
        rst = 1'b0;
        @(negedge clk);
        check("first_req", 32'(imem_req), 32'd1);
        step();
        @(negedge clk);
        check("no_bypass_valid", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_pc", pc_out, 32'hBFC0_0000);
        step();
        p0 = pops;
        repeat (10) step();
        check("throughput_10", 32'(pops - p0), 32'd10);

        // 2: decode stalls; queue fills to DEPTH, requests stop, nothing lost.
        out_ready = 1'b0;
        repeat (10) step();
        @(negedge clk);
        check("stall_req_low", 32'(imem_req), 32'd0);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_occupancy", 32'(grants - pops), 32'd4);
        step();
        out_ready = 1'b1;
        wait_pops(12, 40, "release_drain");

        // 3: branch with two requests in flight.
        lat = 2;
        wait_inflight2("br_inflight");
        redirect(1'b1, 1'b0, 32'h0040_0100, 32'h0040_0100);
        wait_pops(5, 40, "after_branch");

        // 4: exception and branch together; exception vector wins.
        wait_inflight2("exc_inflight");
        redirect(1'b1, 1'b1, 32'h1234_5678, 32'h8000_0080);
        wait_pops(5, 40, "after_except");

        // Back-to-back redirects while stale responses drain; target wraps 2^32.
        lat = 3;
        wait_inflight2("b2b_inflight");
        redirect(1'b1, 1'b0, 32'h0000_1000, 32'h0000_1000);
        redirect(1'b1, 1'b0, 32'hFFFF_FFF8, 32'hFFFF_FFF8);
        wait_pops(6, 60, "after_wrap");

        // 5: latency 3, random grant and ready, redirect every 7 cycles.
        gnt_pct = 60;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 5; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                step();
            end
            e = (r % 3 == 2);
            redirect(1'b1, e, tgt_tab[r], e ? 32'h8000_0080 : tgt_tab[r]);
        end
        out_ready = 1'b1;
        wait_pops(4, 80, "random_tail");

        // 6: reset with the queue partly full and two requests in flight.
        gnt_pct   = 100;
        out_ready = 1'b0;
        repeat (4) step();
        wait_inflight2("rst_inflight");
        rst = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        expect_stream(32'hBFC0_0000);
        @(negedge clk);
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_pc_out", pc_out, 32'd0);
        check("rst_mid_addr", imem_addr, 32'hBFC0_0000);
        check("rst_mid_req", 32'(imem_req), 32'd1);
        step();
        wait_pops(4, 40, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
